// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Opcode/function constants, control-field enums, the ctrl_t
//                bundle carried down the pipe and its all-zero NOP value.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Instruction field positions
  localparam int OPC_W   = 5;
  localparam int OPC_LSB = 11;
  localparam int RX_LSB  = 8;
  localparam int RY_LSB  = 5;
  localparam int RZ_LSB  = 2;

  // Major opcodes (id_inst[15:11])
  localparam logic [OPC_W-1:0] OP_NOP    = 5'b00001;
  localparam logic [OPC_W-1:0] OP_B      = 5'b00010;
  localparam logic [OPC_W-1:0] OP_BEQZ   = 5'b00100;
  localparam logic [OPC_W-1:0] OP_BNEZ   = 5'b00101;
  localparam logic [OPC_W-1:0] OP_ADDIU3 = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ADDIU  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_LI     = 5'b01101;
  localparam logic [OPC_W-1:0] OP_LW     = 5'b10011;
  localparam logic [OPC_W-1:0] OP_SW     = 5'b11011;
  localparam logic [OPC_W-1:0] OP_RRR    = 5'b11100;
  localparam logic [OPC_W-1:0] OP_RR     = 5'b11101;

  // Function codes: RRR group uses [1:0], RR group uses [4:0]
  localparam logic [1:0] FN_ADDU = 2'b01;
  localparam logic [1:0] FN_SUBU = 2'b11;
  localparam logic [4:0] FN_JR   = 5'b00000;
  localparam logic [4:0] FN_AND  = 5'b01100;
  localparam logic [4:0] FN_OR   = 5'b01101;

  // Field widths
  localparam int ALU_OP_W   = 3;
  localparam int ALU_SEL_W  = 2;
  localparam int WB_DATA_W  = 2;
  localparam int JUMP_EN_W  = 2;
  localparam int JUMP_DAT_W = 2;
  localparam int IM_OP_W    = 3;
  localparam int RAM_DAT_W  = 2;
  localparam int WB_ADDR_W  = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_NONE = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_AND = 3'd3, ALU_OR = 3'd4
  } alu_op_e;

  typedef enum logic [ALU_SEL_W-1:0] {
    A_NONE = 2'd0, A_RX = 2'd1, A_RY = 2'd2, A_PC = 2'd3
  } alu_a_op_e;

  typedef enum logic [ALU_SEL_W-1:0] {
    B_NONE = 2'd0, B_RY = 2'd1, B_IM = 2'd2
  } alu_b_op_e;

  typedef enum logic {
    REG_NONE = 1'b0, REG_WR = 1'b1
  } reg_op_e;

  typedef enum logic [WB_DATA_W-1:0] {
    WB_NONE = 2'd0, WB_ALU = 2'd1, WB_RAM = 2'd2
  } wb_data_op_e;

  typedef enum logic {
    RAM_RD = 1'b0, RAM_WR = 1'b1
  } ram_op_e;

  typedef enum logic [JUMP_EN_W-1:0] {
    J_NONE = 2'd0, J_ALWAYS = 2'd1, J_EQZ = 2'd2, J_NEZ = 2'd3
  } jump_en_op_e;

  typedef enum logic [JUMP_DAT_W-1:0] {
    JD_NONE = 2'd0, JD_PC_IM = 2'd1, JD_RX = 2'd2
  } jump_data_op_e;

  typedef enum logic [IM_OP_W-1:0] {
    IM_NONE = 3'd0, IM_S_E_7_0 = 3'd1, IM_S_E_4_0 = 3'd2, IM_S_E_3_0 = 3'd3,
    IM_Z_E_7_0 = 3'd4, IM_S_E_10_0 = 3'd5
  } im_op_e;

  typedef enum logic [RAM_DAT_W-1:0] {
    RDT_NONE = 2'd0, RDT_RY = 2'd1
  } ram_data_op_e;

  // Destination selector, resolved to a GPR index inside the decoder
  typedef enum logic [WB_ADDR_W-1:0] {
    WBA_NONE = 2'd0, WBA_RX = 2'd1, WBA_RY = 2'd2, WBA_RZ = 2'd3
  } wb_addr_op_e;

  typedef struct packed {
    alu_op_e       alu_op;
    alu_a_op_e     alu_a_op;
    alu_b_op_e     alu_b_op;
    reg_op_e       reg_op;
    wb_data_op_e   wb_data_op;
    logic          ram_en;
    ram_op_e       ram_op;
    jump_en_op_e   jump_en_op;
    jump_data_op_e jump_data_op;
    im_op_e        im_op;
    ram_data_op_e  ram_data_op;
  } ctrl_t;

  localparam int    CTRL_W   = $bits(ctrl_t);
  localparam ctrl_t CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_inst_decode.sv
`default_nettype none
// ============================================================================
//  Module      : inst_decode
//  Description : Purely combinational ID-stage decoder: instruction word to
//                control bundle, resolved destination, source-use flags and
//                illegal-opcode flag. Unknown encodings yield CTRL_NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_decode
  import ctrl_pkg::*;
#(
  parameter int INST_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic [INST_W-1:0]     i_inst,
  output ctrl_t                 o_ctrl,
  output logic [REG_ADDR_W-1:0] o_wb_addr,
  output logic                  o_src_a_used,
  output logic                  o_src_b_used,
  output logic                  o_illegal
);

  logic [OPC_W-1:0] w_opc;
  wb_addr_op_e      w_wb_sel;

  assign w_opc = i_inst[OPC_LSB +: OPC_W];

  // Decode opcode/function into the bundle; every path starts from NOP defaults
  always_comb begin
    o_ctrl       = CTRL_NOP;
    w_wb_sel     = WBA_NONE;
    o_src_a_used = 1'b0;
    o_src_b_used = 1'b0;
    o_illegal    = 1'b0;
    case (w_opc)
      OP_NOP: ;
      OP_B: begin
        o_ctrl.jump_en_op   = J_ALWAYS;
        o_ctrl.jump_data_op = JD_PC_IM;
        o_ctrl.im_op        = IM_S_E_10_0;
      end
      OP_BEQZ, OP_BNEZ: begin
        o_ctrl.jump_en_op   = (w_opc == OP_BEQZ) ? J_EQZ : J_NEZ;
        o_ctrl.jump_data_op = JD_PC_IM;
        o_ctrl.im_op        = IM_S_E_7_0;
        o_src_a_used        = 1'b1;
      end
      OP_ADDIU3, OP_ADDIU: begin
        o_ctrl.alu_op     = ALU_ADD;
        o_ctrl.alu_a_op   = A_RX;
        o_ctrl.alu_b_op   = B_IM;
        o_ctrl.im_op      = (w_opc == OP_ADDIU) ? IM_S_E_7_0 : IM_S_E_3_0;
        o_ctrl.reg_op     = REG_WR;
        o_ctrl.wb_data_op = WB_ALU;
        w_wb_sel          = (w_opc == OP_ADDIU) ? WBA_RX : WBA_RY;
        o_src_a_used      = 1'b1;
      end
      OP_LI: begin
        o_ctrl.alu_op     = ALU_ADD;
        o_ctrl.alu_b_op   = B_IM;
        o_ctrl.im_op      = IM_Z_E_7_0;
        o_ctrl.reg_op     = REG_WR;
        o_ctrl.wb_data_op = WB_ALU;
        w_wb_sel          = WBA_RX;
      end
      OP_LW: begin
        o_ctrl.alu_op     = ALU_ADD;
        o_ctrl.alu_a_op   = A_RX;
        o_ctrl.alu_b_op   = B_IM;
        o_ctrl.im_op      = IM_S_E_4_0;
        o_ctrl.reg_op     = REG_WR;
        o_ctrl.wb_data_op = WB_RAM;
        o_ctrl.ram_en     = 1'b1;
        o_ctrl.ram_op     = RAM_RD;
        w_wb_sel          = WBA_RY;
        o_src_a_used      = 1'b1;
      end
      OP_SW: begin
        o_ctrl.alu_op      = ALU_ADD;
        o_ctrl.alu_a_op    = A_RX;
        o_ctrl.alu_b_op    = B_IM;
        o_ctrl.im_op       = IM_S_E_4_0;
        o_ctrl.ram_en      = 1'b1;
        o_ctrl.ram_op      = RAM_WR;
        o_ctrl.ram_data_op = RDT_RY;
        o_src_a_used       = 1'b1;
        o_src_b_used       = 1'b1;
      end
      OP_RRR: begin
        o_ctrl.alu_op     = (i_inst[1:0] == FN_SUBU) ? ALU_SUB : ALU_ADD;
        o_ctrl.alu_a_op   = A_RX;
        o_ctrl.alu_b_op   = B_RY;
        o_ctrl.reg_op     = REG_WR;
        o_ctrl.wb_data_op = WB_ALU;
        w_wb_sel          = WBA_RZ;
        o_src_a_used      = 1'b1;
        o_src_b_used      = 1'b1;
        o_illegal         = (i_inst[1:0] != FN_ADDU) && (i_inst[1:0] != FN_SUBU);
      end
      OP_RR: begin
        if (i_inst[4:0] == FN_JR && i_inst[7:5] == 3'b000) begin
          o_ctrl.jump_en_op   = J_ALWAYS;
          o_ctrl.jump_data_op = JD_RX;
          o_src_a_used        = 1'b1;
        end else if (i_inst[4:0] == FN_AND || i_inst[4:0] == FN_OR) begin
          o_ctrl.alu_op     = (i_inst[4:0] == FN_AND) ? ALU_AND : ALU_OR;
          o_ctrl.alu_a_op   = A_RX;
          o_ctrl.alu_b_op   = B_RY;
          o_ctrl.reg_op     = REG_WR;
          o_ctrl.wb_data_op = WB_ALU;
          w_wb_sel          = WBA_RX;
          o_src_a_used      = 1'b1;
          o_src_b_used      = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: o_illegal = 1'b1;
    endcase
    // An illegal word must carry nothing into the pipe
    if (o_illegal) begin
      o_ctrl       = CTRL_NOP;
      w_wb_sel     = WBA_NONE;
      o_src_a_used = 1'b0;
      o_src_b_used = 1'b0;
    end
  end

  // Resolve destination selector to a GPR index (0 when nothing is written)
  always_comb begin
    o_wb_addr = '0;
    case (w_wb_sel)
      WBA_RX:  o_wb_addr = i_inst[RX_LSB +: REG_ADDR_W];
      WBA_RY:  o_wb_addr = i_inst[RY_LSB +: REG_ADDR_W];
      WBA_RZ:  o_wb_addr = i_inst[RZ_LSB +: REG_ADDR_W];
      default: o_wb_addr = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipe
//  Description : Decodes the ID instruction and carries its control bundle
//                through NUM_STAGES registered stages (EX .. WB). Handles
//                memory-stall freeze, branch flush and load-use interlock.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int INST_W         = 16,
  parameter int REG_ADDR_W     = 3,
  parameter int NUM_STAGES     = 3,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic                  clk_50MHz,
  input  logic                  rst,
  input  logic                  i_id_valid,
  input  logic [INST_W-1:0]     i_id_inst,
  input  logic                  i_flush,
  input  logic                  i_mem_stall,
  output logic                  o_stall_id,
  output logic                  o_illegal_inst,
  output logic                  o_ex_valid,
  output logic                  o_mem_valid,
  output logic                  o_wb_valid,
  output logic [CTRL_W-1:0]     o_ex_ctrl,
  output logic [CTRL_W-1:0]     o_mem_ctrl,
  output logic [CTRL_W-1:0]     o_wb_ctrl,
  output logic [REG_ADDR_W-1:0] o_ex_wb_addr,
  output logic [REG_ADDR_W-1:0] o_mem_wb_addr,
  output logic [REG_ADDR_W-1:0] o_wb_wb_addr
);

  localparam int MEM_IDX = NUM_STAGES - 2;
  localparam int WB_IDX  = NUM_STAGES - 1;

  ctrl_t                  w_dec_ctrl;
  logic [REG_ADDR_W-1:0]  w_dec_wb_addr;
  logic                   w_src_a_used;
  logic                   w_src_b_used;
  logic                   w_dec_illegal;
  logic [REG_ADDR_W-1:0]  w_rx;
  logic [REG_ADDR_W-1:0]  w_ry;
  logic                   w_ex_is_load;
  logic                   w_load_use;

  logic                   r_valid [NUM_STAGES];
  ctrl_t                  r_ctrl  [NUM_STAGES];
  logic [REG_ADDR_W-1:0]  r_addr  [NUM_STAGES];

  inst_decode #(
    .INST_W     (INST_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_inst_decode (
    .i_inst       (i_id_inst),
    .o_ctrl       (w_dec_ctrl),
    .o_wb_addr    (w_dec_wb_addr),
    .o_src_a_used (w_src_a_used),
    .o_src_b_used (w_src_b_used),
    .o_illegal    (w_dec_illegal)
  );

  assign w_rx = i_id_inst[RX_LSB +: REG_ADDR_W];
  assign w_ry = i_id_inst[RY_LSB +: REG_ADDR_W];

  // Load in EX whose destination is read by the ID instruction
  always_comb begin
    w_ex_is_load = r_valid[0] && r_ctrl[0].ram_en && (r_ctrl[0].ram_op == RAM_RD)
                   && (r_ctrl[0].reg_op == REG_WR);
    w_load_use   = (LOAD_USE_STALL != 0) && w_ex_is_load && i_id_valid
                   && ((w_src_a_used && (w_rx == r_addr[0]))
                       || (w_src_b_used && (w_ry == r_addr[0])));
  end

  // mem_stall dominates; flush beats the interlock so a squashed consumer never stalls
  assign o_stall_id     = !rst && (i_mem_stall || (!i_flush && w_load_use));
  assign o_illegal_inst = !rst && i_id_valid && w_dec_illegal && !i_mem_stall
                          && !i_flush && !w_load_use;

  // Stage registers: freeze on mem_stall, bubble EX on flush/interlock, else shift
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        r_valid[s] <= 1'b0;
        r_ctrl[s]  <= CTRL_NOP;
        r_addr[s]  <= '0;
      end
    end else if (!i_mem_stall) begin
      for (int s = NUM_STAGES - 1; s > 0; s--) begin
        r_valid[s] <= r_valid[s-1];
        r_ctrl[s]  <= r_ctrl[s-1];
        r_addr[s]  <= r_addr[s-1];
      end
      if (i_flush || w_load_use) begin
        r_valid[0] <= 1'b0;
        r_ctrl[0]  <= CTRL_NOP;
        r_addr[0]  <= '0;
      end else begin
        r_valid[0] <= i_id_valid;
        r_ctrl[0]  <= w_dec_ctrl;
        r_addr[0]  <= w_dec_wb_addr;
      end
    end
  end

  assign o_ex_valid    = r_valid[0];
  assign o_mem_valid   = r_valid[MEM_IDX];
  assign o_wb_valid    = r_valid[WB_IDX];
  assign o_ex_ctrl     = r_ctrl[0];
  assign o_mem_ctrl    = r_ctrl[MEM_IDX];
  assign o_wb_ctrl     = r_ctrl[WB_IDX];
  assign o_ex_wb_addr  = r_addr[0];
  assign o_mem_wb_addr = r_addr[MEM_IDX];
  assign o_wb_wb_addr  = r_addr[WB_IDX];

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_pipe
//  Description : Directed self-checking bench for ctrl_pipe; a second
//                instance without the load-use interlock shares the stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  localparam int INST_W = 16;
  localparam int RA_W   = 3;

  // Hand-derived bundles for the instructions used below
  localparam ctrl_t EXP_ADDIU = '{alu_op: ALU_ADD, alu_a_op: A_RX, alu_b_op: B_IM,
    reg_op: REG_WR, wb_data_op: WB_ALU, ram_en: 1'b0, ram_op: RAM_RD, jump_en_op: J_NONE,
    jump_data_op: JD_NONE, im_op: IM_S_E_7_0, ram_data_op: RDT_NONE};
  localparam ctrl_t EXP_LW = '{alu_op: ALU_ADD, alu_a_op: A_RX, alu_b_op: B_IM,
    reg_op: REG_WR, wb_data_op: WB_RAM, ram_en: 1'b1, ram_op: RAM_RD, jump_en_op: J_NONE,
    jump_data_op: JD_NONE, im_op: IM_S_E_4_0, ram_data_op: RDT_NONE};
  localparam ctrl_t EXP_ADDU = '{alu_op: ALU_ADD, alu_a_op: A_RX, alu_b_op: B_RY,
    reg_op: REG_WR, wb_data_op: WB_ALU, ram_en: 1'b0, ram_op: RAM_RD, jump_en_op: J_NONE,
    jump_data_op: JD_NONE, im_op: IM_NONE, ram_data_op: RDT_NONE};

  logic              clk_50MHz;
  logic              rst;
  logic              id_valid;
  logic [INST_W-1:0] id_inst;
  logic              flush;
  logic              mem_stall;

  logic            stall_id, illegal_inst, ex_valid, mem_valid, wb_valid;
  ctrl_t           ex_ctrl, mem_ctrl, wb_ctrl;
  logic [RA_W-1:0] ex_wa, mem_wa, wb_wa;

  logic            nl_stall_id, nl_illegal, nl_ex_valid, nl_mem_valid, nl_wb_valid;
  ctrl_t           nl_ex_ctrl, nl_mem_ctrl, nl_wb_ctrl;
  logic [RA_W-1:0] nl_ex_wa, nl_mem_wa, nl_wb_wa;

  int n_cmp = 0;
  int n_err = 0;

  ctrl_pipe #(.INST_W(INST_W), .REG_ADDR_W(RA_W), .NUM_STAGES(3), .LOAD_USE_STALL(1)) u_dut (
    .clk_50MHz(clk_50MHz), .rst(rst), .i_id_valid(id_valid), .i_id_inst(id_inst),
    .i_flush(flush), .i_mem_stall(mem_stall), .o_stall_id(stall_id),
    .o_illegal_inst(illegal_inst), .o_ex_valid(ex_valid), .o_mem_valid(mem_valid),
    .o_wb_valid(wb_valid), .o_ex_ctrl(ex_ctrl), .o_mem_ctrl(mem_ctrl), .o_wb_ctrl(wb_ctrl),
    .o_ex_wb_addr(ex_wa), .o_mem_wb_addr(mem_wa), .o_wb_wb_addr(wb_wa)
  );

  ctrl_pipe #(.INST_W(INST_W), .REG_ADDR_W(RA_W), .NUM_STAGES(3), .LOAD_USE_STALL(0)) u_dut_nl (
    .clk_50MHz(clk_50MHz), .rst(rst), .i_id_valid(id_valid), .i_id_inst(id_inst),
    .i_flush(flush), .i_mem_stall(mem_stall), .o_stall_id(nl_stall_id),
    .o_illegal_inst(nl_illegal), .o_ex_valid(nl_ex_valid), .o_mem_valid(nl_mem_valid),
    .o_wb_valid(nl_wb_valid), .o_ex_ctrl(nl_ex_ctrl), .o_mem_ctrl(nl_mem_ctrl),
    .o_wb_ctrl(nl_wb_ctrl), .o_ex_wb_addr(nl_ex_wa), .o_mem_wb_addr(nl_mem_wa),
    .o_wb_wb_addr(nl_wb_wa)
  );

  initial clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later
  task automatic tick;
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic drive(input logic v, input logic [INST_W-1:0] inst);
    id_valid = v;
    id_inst  = inst;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mem_stall = 1'b0;
    drive(1'b0, 16'h0800);
    tick; tick;

    // Reset state
    chk("rst_ex_valid",  32'(ex_valid), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_wb_valid",  32'(wb_valid), 32'd0);
    chk("rst_ex_ctrl",   32'(ex_ctrl), 32'(CTRL_NOP));
    chk("rst_wb_addr",   32'(wb_wa), 32'd0);
    chk("rst_illegal",   32'(illegal_inst), 32'd0);
    mem_stall = 1'b1; #1;
    chk("rst_stall_id",  32'(stall_id), 32'd0);
    mem_stall = 1'b0;
    rst = 1'b0;

    // ADDIU R1,5 flows EX -> MEM -> WB
    drive(1'b1, 16'h4905); #1;
    chk("addiu_stall", 32'(stall_id), 32'd0);
    tick; drive(1'b0, 16'h0800);
    chk("addiu_ex_valid", 32'(ex_valid), 32'd1);
    chk("addiu_ex_ctrl",  32'(ex_ctrl), 32'(EXP_ADDIU));
    chk("addiu_alu_op",   32'(ex_ctrl.alu_op), 32'(ALU_ADD));
    chk("addiu_alu_b",    32'(ex_ctrl.alu_b_op), 32'(B_IM));
    chk("addiu_im_op",    32'(ex_ctrl.im_op), 32'(IM_S_E_7_0));
    chk("addiu_ex_wa",    32'(ex_wa), 32'd1);
    tick;
    chk("addiu_mem_valid", 32'(mem_valid), 32'd1);
    chk("addiu_ex_empty",  32'(ex_valid), 32'd0);
    tick;
    chk("addiu_wb_valid", 32'(wb_valid), 32'd1);
    chk("addiu_wb_ctrl",  32'(wb_ctrl), 32'(EXP_ADDIU));
    chk("addiu_wb_wa",    32'(wb_wa), 32'd1);

    // Load-use: LW R1,0(R2) then ADDU R3,R1,R4
    drive(1'b1, 16'h9A20);
    tick;
    chk("lw_ex_ctrl", 32'(ex_ctrl), 32'(EXP_LW));
    chk("lw_ex_wa",   32'(ex_wa), 32'd1);
    drive(1'b1, 16'hE18D); #1;
    chk("lu_stall_id",    32'(stall_id), 32'd1);
    chk("lu_nl_stall_id", 32'(nl_stall_id), 32'd0);
    chk("lu_illegal",     32'(illegal_inst), 32'd0);
    tick;
    chk("lu_ex_bubble",   32'(ex_valid), 32'd0);
    chk("lu_ex_nop",      32'(ex_ctrl), 32'(CTRL_NOP));
    chk("lu_mem_valid",   32'(mem_valid), 32'd1);
    chk("lu_mem_ctrl",    32'(mem_ctrl), 32'(EXP_LW));
    chk("lu_mem_wa",      32'(mem_wa), 32'd1);
    chk("lu_stall_clear", 32'(stall_id), 32'd0);
    chk("lu_nl_ex_valid", 32'(nl_ex_valid), 32'd1);
    chk("lu_nl_ex_wa",    32'(nl_ex_wa), 32'd3);
    tick;
    drive(1'b0, 16'h0800);
    chk("addu_ex_valid", 32'(ex_valid), 32'd1);
    chk("addu_ex_wa",    32'(ex_wa), 32'd3);
    chk("addu_ex_ctrl",  32'(ex_ctrl), 32'(EXP_ADDU));
    chk("addu_lw_at_wb", 32'(wb_valid), 32'd1);

    // Flush in the would-be stall cycle squashes the consumer
    drive(1'b1, 16'h9A20);
    tick;
    drive(1'b1, 16'hE18D); flush = 1'b1; #1;
    chk("fl_stall_id", 32'(stall_id), 32'd0);
    chk("fl_illegal",  32'(illegal_inst), 32'd0);
    tick;
    flush = 1'b0; drive(1'b0, 16'h0800);
    chk("fl_ex_bubble", 32'(ex_valid), 32'd0);
    chk("fl_mem_lw",    32'(mem_valid), 32'd1);
    chk("fl_mem_wa",    32'(mem_wa), 32'd1);
    tick;
    chk("fl_addu_gone", 32'(ex_valid), 32'd0);

    // mem_stall freeze with pipe full: ex=LI R3, mem=ADDIU R2, wb=ADDIU R1
    drive(1'b1, 16'h4905); tick;
    drive(1'b1, 16'h4A07); tick;
    drive(1'b1, 16'h6B09); tick;
    drive(1'b1, 16'h4C01); mem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ms_stall_id", 32'(stall_id), 32'd1);
      chk("ms_ex_wa",    32'(ex_wa), 32'd3);
      chk("ms_mem_wa",   32'(mem_wa), 32'd2);
      chk("ms_wb_wa",    32'(wb_wa), 32'd1);
      chk("ms_wb_valid", 32'(wb_valid), 32'd1);
      tick;
    end
    mem_stall = 1'b0; #1;
    chk("ms_release_stall", 32'(stall_id), 32'd0);
    tick;
    drive(1'b0, 16'h0800);
    chk("ms_r1_ex_wa",  32'(ex_wa), 32'd4);
    chk("ms_r1_mem_wa", 32'(mem_wa), 32'd3);
    chk("ms_r1_wb_wa",  32'(wb_wa), 32'd2);
    tick;
    chk("ms_r2_ex_valid", 32'(ex_valid), 32'd0);
    chk("ms_r2_mem_wa",   32'(mem_wa), 32'd4);
    chk("ms_r2_wb_wa",    32'(wb_wa), 32'd3);
    tick;
    chk("ms_r3_wb_wa",     32'(wb_wa), 32'd4);
    chk("ms_r3_wb_valid",  32'(wb_valid), 32'd1);
    chk("ms_r3_mem_valid", 32'(mem_valid), 32'd0);

    // Illegal opcode held under mem_stall, then accepted
    drive(1'b1, 16'hF800); mem_stall = 1'b1; #1;
    chk("ill_held_pulse", 32'(illegal_inst), 32'd0);
    chk("ill_held_stall", 32'(stall_id), 32'd1);
    tick;
    chk("ill_held_pulse2", 32'(illegal_inst), 32'd0);
    mem_stall = 1'b0; #1;
    chk("ill_pulse", 32'(illegal_inst), 32'd1);
    tick;
    drive(1'b0, 16'h0800);
    chk("ill_ex_valid", 32'(ex_valid), 32'd1);
    chk("ill_ex_ctrl",  32'(ex_ctrl), 32'(CTRL_NOP));
    chk("ill_ex_wa",    32'(ex_wa), 32'd0);
    #1;
    chk("ill_pulse_end", 32'(illegal_inst), 32'd0);

    // Asynchronous reset mid-stream, then NOP flows to WB
    drive(1'b1, 16'h4905); tick;
    drive(1'b1, 16'h4A07); tick;
    drive(1'b1, 16'h6B09); tick;
    drive(1'b0, 16'h0800);
    chk("mr_full", 32'(wb_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("mr_ex_valid",  32'(ex_valid), 32'd0);
    chk("mr_mem_valid", 32'(mem_valid), 32'd0);
    chk("mr_wb_valid",  32'(wb_valid), 32'd0);
    chk("mr_ex_ctrl",   32'(ex_ctrl), 32'(CTRL_NOP));
    chk("mr_mem_ctrl",  32'(mem_ctrl), 32'(CTRL_NOP));
    chk("mr_wb_ctrl",   32'(wb_ctrl), 32'(CTRL_NOP));
    chk("mr_ex_wa",     32'(ex_wa), 32'd0);
    chk("mr_wb_wa",     32'(wb_wa), 32'd0);
    tick;
    rst = 1'b0;
    drive(1'b1, 16'h0800);
    tick;
    drive(1'b0, 16'h0800);
    chk("nop_ex_valid", 32'(ex_valid), 32'd1);
    chk("nop_ex_ctrl",  32'(ex_ctrl), 32'(CTRL_NOP));
    tick; tick;
    chk("nop_wb_valid", 32'(wb_valid), 32'd1);
    chk("nop_wb_ctrl",  32'(wb_ctrl), 32'(CTRL_NOP));
    chk("nop_wb_wa",    32'(wb_wa), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
